// File: rtl/bram_pkg.sv
// rtl/bram_pkg.sv - shared types and constants for the byte-enable SDP block RAM
package bram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    READY = 2'd2
  } state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

endpackage

// File: rtl/bram_sdp_array.sv
// rtl/bram_sdp_array.sv - storage array with per-lane write and registered read
module bram_sdp_array #(
  parameter int ADDR_WIDTH = 12,
  parameter int NB_COL     = 4,
  parameter int COL_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic [NB_COL-1:0]             we,
  input  logic [ADDR_WIDTH-1:0]         waddr,
  input  logic [NB_COL*COL_WIDTH-1:0]   wdi,
  input  logic                          re,
  input  logic [ADDR_WIDTH-1:0]         raddr,
  output logic [NB_COL*COL_WIDTH-1:0]   rdo
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [NB_COL*COL_WIDTH-1:0] mem [DEPTH];

  // Lane-masked write and read-before-write registered read; no reset so it maps to block RAM
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB_COL; i++) begin
      if (we[i]) begin
        mem[waddr][i*COL_WIDTH +: COL_WIDTH] <= wdi[i*COL_WIDTH +: COL_WIDTH];
      end
    end
    if (re) begin
      rdo <= mem[raddr];
    end
  end

endmodule

// File: rtl/bram_sdp_be.sv
// rtl/bram_sdp_be.sv - simple dual-port byte-enable RAM with zero-fill and read pipeline
module bram_sdp_be
  import bram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 12,
  parameter int NB_COL         = 4,
  parameter int COL_WIDTH      = 8,
  parameter int RD_LATENCY     = 1,
  parameter int WRITE_FIRST    = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic                          init_busy,
  input  logic [NB_COL-1:0]             we,
  input  logic [ADDR_WIDTH-1:0]         waddr,
  input  logic [NB_COL*COL_WIDTH-1:0]   wdi,
  input  logic                          re,
  input  logic [ADDR_WIDTH-1:0]         raddr,
  output logic [NB_COL*COL_WIDTH-1:0]   rdo,
  output logic                          rvalid
);

  localparam int DATA_WIDTH = NB_COL*COL_WIDTH;

  if (RD_LATENCY < RD_LAT_MIN || RD_LATENCY > RD_LAT_MAX) begin : g_bad_latency
    $error("bram_sdp_be: RD_LATENCY must be 1 or 2");
  end

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic                    clearing, ready, rd_acc;
  logic [NB_COL-1:0]       user_we, arr_we;
  logic [ADDR_WIDTH-1:0]   arr_waddr;
  logic [DATA_WIDTH-1:0]   arr_wdi, arr_rdo, merged;
  logic                    v0;
  logic [NB_COL-1:0]       col_we;
  logic [DATA_WIDTH-1:0]   col_wdi;

  assign clearing  = (state == CLEAR);
  assign ready     = (state == READY);
  assign init_busy = clearing;
  assign user_we   = ready ? we : '0;
  assign rd_acc    = ready & re;
  assign arr_we    = clearing ? '1 : user_we;
  assign arr_waddr = clearing ? clr_cnt : waddr;
  assign arr_wdi   = clearing ? '0 : wdi;

  bram_sdp_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NB_COL     (NB_COL),
    .COL_WIDTH  (COL_WIDTH)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdi   (arr_wdi),
    .re    (rd_acc),
    .raddr (raddr),
    .rdo   (arr_rdo)
  );

  // State register; reset parks in IDLE until rst_n is released
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: IDLE leaves straight away, CLEAR ends after the last address is zeroed
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      CLEAR:   if (&clr_cnt) state_nxt = READY;
      READY:   state_nxt = READY;
      default: state_nxt = IDLE;
    endcase
  end

  // Clear address counter; saturates at the top address instead of wrapping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clr_cnt <= '0;
    end else if (clearing && !(&clr_cnt)) begin
      clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
    end
  end

  // First pipeline stage valid: tracks the array read issued this edge
  always_ff @(posedge clk) begin
    if (!rst_n) v0 <= 1'b0;
    else        v0 <= rd_acc;
  end

  // Remember which lanes a same-address write overwrote, for write-first bypass
  always_ff @(posedge clk) begin
    col_we  <= ((WRITE_FIRST != 0) && (waddr == raddr)) ? user_we : '0;
    col_wdi <= wdi;
  end

  // Substitute freshly written lanes over the array's old data
  always_comb begin
    merged = arr_rdo;
    for (int i = 0; i < NB_COL; i++) begin
      if (col_we[i]) merged[i*COL_WIDTH +: COL_WIDTH] = col_wdi[i*COL_WIDTH +: COL_WIDTH];
    end
  end

  if (RD_LATENCY == 1) begin : g_lat1
    // Output register; rdo only moves when a read completes
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rvalid <= 1'b0;
        rdo    <= '0;
      end else begin
        rvalid <= v0;
        if (v0) rdo <= merged;
      end
    end
  end else begin : g_lat2
    logic                  v1;
    logic [DATA_WIDTH-1:0] d1;

    // Extra stage so a read returns two cycles after it is accepted
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v1     <= 1'b0;
        rvalid <= 1'b0;
        rdo    <= '0;
      end else begin
        v1     <= v0;
        rvalid <= v1;
        if (v1) rdo <= d1;
      end
    end

    // Data half of the extra stage, no reset needed
    always_ff @(posedge clk) begin
      if (v0) d1 <= merged;
    end
  end

endmodule

// File: tb/tb_bram_sdp_be.sv
// tb/tb_bram_sdp_be.sv - self-checking bench for bram_sdp_be
module tb_bram_sdp_be;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  we;
  logic [3:0]  waddr;
  logic [31:0] wdi;
  logic        re;
  logic [3:0]  raddr;

  logic        busy1, rvalid1, busy2, rvalid2;
  logic [31:0] rdo1, rdo2;

  always #5 clk = ~clk;

  // DUT 1: latency 1, write-first
  bram_sdp_be #(.ADDR_WIDTH(4), .NB_COL(4), .COL_WIDTH(8), .RD_LATENCY(1),
                .WRITE_FIRST(1), .CLEAR_ON_RESET(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .init_busy(busy1), .we(we), .waddr(waddr), .wdi(wdi),
    .re(re), .raddr(raddr), .rdo(rdo1), .rvalid(rvalid1));

  // DUT 2: latency 2, read-first (old data)
  bram_sdp_be #(.ADDR_WIDTH(4), .NB_COL(4), .COL_WIDTH(8), .RD_LATENCY(2),
                .WRITE_FIRST(0), .CLEAR_ON_RESET(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .init_busy(busy2), .we(we), .waddr(waddr), .wdi(wdi),
    .re(re), .raddr(raddr), .rdo(rdo2), .rvalid(rvalid2));

  typedef struct {
    int          due;
    logic [31:0] data;
  } rd_t;

  typedef struct {
    logic [3:0]  we;
    logic [3:0]  waddr;
    logic [31:0] wdi;
    logic        re;
    logic [3:0]  raddr;
    logic [31:0] exp_wf1;
    logic [31:0] exp_wf0;
  } vec_t;

  rd_t         q1[$], q2[$];
  logic [31:0] mem [16];
  int          mode;      // 0 held in reset, 1 zero-filling, 2 usable
  int          clr_idx;
  int          cyc = 0;
  logic [31:0] last1 = '0, last2 = '0;
  int          checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic set_idle();
    we = '0; waddr = '0; wdi = '0; re = 1'b0; raddr = '0;
  endtask

  // Advance the reference by one edge, clock the DUTs, then compare every output.
  task automatic cycle(input logic use_c, input logic [31:0] c1, input logic [31:0] c0);
    logic [31:0] old_d, new_d;
    if (!rst_n) begin
      mode = 0; q1.delete(); q2.delete(); last1 = '0; last2 = '0;
    end else if (mode == 0) begin
      mode = 1; clr_idx = 0;
    end else if (mode == 1) begin
      mem[clr_idx] = '0;
      clr_idx++;
      if (clr_idx == 16) mode = 2;
    end else begin
      if (re) begin
        old_d = mem[raddr];
        new_d = old_d;
        if (waddr == raddr)
          for (int i = 0; i < 4; i++) if (we[i]) new_d[i*8 +: 8] = wdi[i*8 +: 8];
        q1.push_back('{cyc + 2, use_c ? c1 : new_d});
        q2.push_back('{cyc + 3, use_c ? c0 : old_d});
      end
      for (int i = 0; i < 4; i++) if (we[i]) mem[waddr][i*8 +: 8] = wdi[i*8 +: 8];
    end
    @(posedge clk); #1;
    cyc++;
    chk("busy1", {31'd0, busy1}, {31'd0, mode == 1});
    chk("busy2", {31'd0, busy2}, {31'd0, mode == 1});
    if (q1.size() > 0 && q1[0].due == cyc) begin
      last1 = q1[0].data; void'(q1.pop_front());
      chk("rvalid1", {31'd0, rvalid1}, 32'd1);
    end else begin
      chk("rvalid1", {31'd0, rvalid1}, 32'd0);
    end
    chk("rdo1", rdo1, last1);
    if (q2.size() > 0 && q2[0].due == cyc) begin
      last2 = q2[0].data; void'(q2.pop_front());
      chk("rvalid2", {31'd0, rvalid2}, 32'd1);
    end else begin
      chk("rvalid2", {31'd0, rvalid2}, 32'd0);
    end
    chk("rdo2", rdo2, last2);
  endtask

  task automatic step();
    cycle(1'b0, '0, '0);
  endtask

  // Count init_busy high cycles after reset release, optionally poking re/we meanwhile.
  task automatic count_clear(input logic poke);
    int n1 = 0, n2 = 0;
    for (int k = 0; k < 40; k++) begin
      if (poke) begin
        re = k[0]; raddr = 4'($urandom);
        we = k[0] ? 4'hF : 4'h0; waddr = 4'($urandom); wdi = $urandom | 32'h1;
      end
      step();
      if (busy1) n1++;
      if (busy2) n2++;
      if (n1 > 0 && !busy1 && !busy2) break;
    end
    set_idle();
    chk("clear_len1", n1, 16);
    chk("clear_len2", n2, 16);
  endtask

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{4'hF, 4'd3, 32'hAABBCCDD, 1'b0, 4'd0,  32'h0,        32'h0};
    tbl[1]  = '{4'h5, 4'd3, 32'h11223344, 1'b0, 4'd0,  32'h0,        32'h0};
    tbl[2]  = '{4'h0, 4'd0, 32'h0,        1'b1, 4'd3,  32'hAA22CC44, 32'hAA22CC44};
    tbl[3]  = '{4'hF, 4'd5, 32'hFFFFFFFF, 1'b0, 4'd0,  32'h0,        32'h0};
    tbl[4]  = '{4'hF, 4'd5, 32'h12345678, 1'b1, 4'd5,  32'h12345678, 32'hFFFFFFFF};
    tbl[5]  = '{4'h0, 4'd0, 32'h0,        1'b1, 4'd5,  32'h12345678, 32'h12345678};
    tbl[6]  = '{4'h3, 4'd9, 32'h0000BEEF, 1'b1, 4'd9,  32'h0000BEEF, 32'h00000000};
    tbl[7]  = '{4'h0, 4'd0, 32'h0,        1'b1, 4'd9,  32'h0000BEEF, 32'h0000BEEF};
    tbl[8]  = '{4'hF, 4'd1, 32'hCAFEF00D, 1'b1, 4'd3,  32'hAA22CC44, 32'hAA22CC44};
    tbl[9]  = '{4'h0, 4'd0, 32'h0,        1'b1, 4'd1,  32'hCAFEF00D, 32'hCAFEF00D};
    tbl[10] = '{4'h0, 4'd0, 32'h0,        1'b1, 4'd15, 32'h0,        32'h0};
    tbl[11] = '{4'h0, 4'd0, 32'h0,        1'b1, 4'd0,  32'h0,        32'h0};

    rst_n = 1'b0;
    set_idle();
    for (int k = 0; k < 3; k++) step();
    rst_n = 1'b1;
    count_clear(1'b0);

    for (int k = 0; k < 12; k++) begin
      we = tbl[k].we; waddr = tbl[k].waddr; wdi = tbl[k].wdi;
      re = tbl[k].re; raddr = tbl[k].raddr;
      cycle(tbl[k].re, tbl[k].exp_wf1, tbl[k].exp_wf0);
    end
    set_idle();
    for (int k = 0; k < 3; k++) step();

    // Four back-to-back reads, then drain
    for (int k = 0; k < 4; k++) begin
      re = 1'b1; raddr = 4'(k * 2 + 1);
      step();
    end
    set_idle();
    for (int k = 0; k < 4; k++) step();

    // Random traffic against the reference
    for (int k = 0; k < 300; k++) begin
      we = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
      waddr = 4'($urandom); wdi = $urandom;
      re = 1'($urandom); raddr = 4'($urandom);
      step();
    end
    set_idle();
    for (int k = 0; k < 4; k++) step();

    // Fill every address, then reset mid-clear at address 7 with reads in flight
    for (int k = 0; k < 16; k++) begin
      we = 4'hF; waddr = 4'(k); wdi = 32'h5A000000 | k; re = 1'b1; raddr = 4'(15 - k);
      step();
    end
    re = 1'b1; raddr = 4'd2; set_idle(); re = 1'b1;
    rst_n = 1'b0; step();
    set_idle(); rst_n = 1'b1;
    for (int k = 0; k < 20 && !(mode == 1 && clr_idx == 7); k++) step();
    chk("clr_at_7", clr_idx, 7);
    rst_n = 1'b0; step();
    rst_n = 1'b1;
    count_clear(1'b1);

    for (int k = 0; k < 16; k++) begin
      re = 1'b1; raddr = 4'(k);
      cycle(1'b1, 32'h0, 32'h0);
    end
    set_idle();
    for (int k = 0; k < 4; k++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
